// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : reset_sequencer
// Purpose  : Multi-domain reset controller. All STAGES reset outputs assert
//            together. They then release one at a time in order 0..STAGES-1.
//            Each release waits STAGE_DELAY edges. The next stage starts only
//            after the released domain acknowledges on ready[k]. A missing
//            acknowledge (TIMEOUT edges) sets a sticky fault and restarts the
//            sequence. Any synchronous request restarts it as well.
// Ports    : clk        - system clock, rising edge
//            reset_in   - asynchronous active-high master reset
//            req        - synchronous restart requests (any bit high)
//            ready      - per-domain "up" acknowledge
//            reset_out  - per-domain active-high reset
//            busy       - sequence in progress (not in RUN)
//            fault      - sticky ready timeout since last reset_in
//            last_cause - req vector of the latest restart, 0 = reset_in
// Revision : 1.0 - initial release
// ============================================================================
module reset_sequencer #(
  parameter int STAGES      = 3,
  parameter int REQUESTERS  = 2,
  parameter int STAGE_DELAY = 4,
  parameter int TIMEOUT     = 16
) (
  input  logic                  clk,
  input  logic                  reset_in,
  input  logic [REQUESTERS-1:0] req,
  input  logic [STAGES-1:0]     ready,
  output logic [STAGES-1:0]     reset_out,
  output logic                  busy,
  output logic                  fault,
  output logic [REQUESTERS-1:0] last_cause
);

  // The counter is shared between the delay and the ack-timeout phases,
  // so it is sized for the larger of the two terminal counts.
  localparam int c_cnt_max = (STAGE_DELAY > TIMEOUT) ? STAGE_DELAY : TIMEOUT;
  localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
  localparam int c_stg_w   = (STAGES > 1) ? $clog2(STAGES) : 1;

  // Terminal values are one less than the edge count because the counter
  // starts at 0 on the first edge spent in a state.
  localparam logic [c_cnt_w-1:0] c_delay_last   = c_cnt_w'(STAGE_DELAY - 1);
  localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'(TIMEOUT - 1);
  localparam logic [c_stg_w-1:0] c_stage_last   = c_stg_w'(STAGES - 1);

  generate
    if ((STAGES < 1) || (REQUESTERS < 1) || (STAGE_DELAY < 1) || (TIMEOUT < 1)) begin : g_param_check
      $error("reset_sequencer: all parameters must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_DELAY = 2'd0,
    ST_ACK   = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_stg_w-1:0]   r_stage;
  logic [c_cnt_w-1:0]   r_count;

  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      r_state    <= ST_DELAY;
      r_stage    <= '0;
      r_count    <= '0;
      reset_out  <= '1;
      busy       <= 1'b1;
      fault      <= 1'b0;
      last_cause <= '0;
    end else if (|req) begin
      // A request outranks delay/ack progress and a same-edge timeout.
      // While req stays high the counter is held at 0, so counting starts
      // on the first edge after req drops.
      r_state    <= ST_DELAY;
      r_stage    <= '0;
      r_count    <= '0;
      reset_out  <= '1;
      busy       <= 1'b1;
      last_cause <= req;
    end else begin
      case (r_state)
        ST_DELAY: begin
          if (r_count == c_delay_last) begin
            reset_out[r_stage] <= 1'b0;
            r_count            <= '0;
            r_state            <= ST_ACK;
          end else begin
            r_count <= r_count + c_cnt_w'(1);
          end
        end

        ST_ACK: begin
          // ready is checked ahead of the timeout, so an acknowledge on the
          // final timeout edge still counts as success.
          if (ready[r_stage]) begin
            r_count <= '0;
            if (r_stage == c_stage_last) begin
              r_state <= ST_RUN;
              busy    <= 1'b0;
            end else begin
              r_stage <= r_stage + c_stg_w'(1);
              r_state <= ST_DELAY;
            end
          end else if (r_count == c_timeout_last) begin
            fault     <= 1'b1;
            reset_out <= '1;
            r_stage   <= '0;
            r_count   <= '0;
            r_state   <= ST_DELAY;
          end else begin
            r_count <= r_count + c_cnt_w'(1);
          end
        end

        ST_RUN: begin
          reset_out <= '0;
          busy      <= 1'b0;
        end

        default: begin
          // Unreachable encoding: recover by restarting the sequence.
          r_state   <= ST_DELAY;
          r_stage   <= '0;
          r_count   <= '0;
          reset_out <= '1;
          busy      <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reset_sequencer
// Purpose  : Self-checking bench for reset_sequencer. One instance uses the
//            default parameters. A second instance uses STAGES=1,
//            STAGE_DELAY=1 and TIMEOUT=1 for boundary timing. Per-cycle
//            vectors carry inputs and expected outputs. Expected values are
//            queued when a vector is driven and compared after the edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset_a = 1'b1;
  logic [1:0] req_a = 2'b00;
  logic [2:0] ready_a = 3'b111;
  logic [2:0] reset_out_a;
  logic       busy_a, fault_a;
  logic [1:0] last_cause_a;

  logic       reset_b = 1'b1;
  logic [1:0] req_b = 2'b00;
  logic [0:0] ready_b = 1'b1;
  logic [0:0] reset_out_b;
  logic       busy_b, fault_b;
  logic [1:0] last_cause_b;

  always #5 clk = ~clk;

  reset_sequencer dut_a (
    .clk        (clk),
    .reset_in   (reset_a),
    .req        (req_a),
    .ready      (ready_a),
    .reset_out  (reset_out_a),
    .busy       (busy_a),
    .fault      (fault_a),
    .last_cause (last_cause_a)
  );

  reset_sequencer #(
    .STAGES      (1),
    .REQUESTERS  (2),
    .STAGE_DELAY (1),
    .TIMEOUT     (1)
  ) dut_b (
    .clk        (clk),
    .reset_in   (reset_b),
    .req        (req_b),
    .ready      (ready_b),
    .reset_out  (reset_out_b),
    .busy       (busy_b),
    .fault      (fault_b),
    .last_cause (last_cause_b)
  );

  typedef struct {
    bit         sel;   // 0 = default instance, 1 = boundary instance
    bit         rst;
    logic [1:0] req;
    logic [2:0] rdy;
    logic [2:0] ro;
    bit         busy;
    bit         flt;
    logic [1:0] lc;
    int         sc;
    int         n;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   applied     = 0;
  int   miscompares = 0;

  task automatic add(input bit sel, input bit rst, input logic [1:0] rq,
                     input logic [2:0] rd, input logic [2:0] ro, input bit bz,
                     input bit fl, input logic [1:0] lc, input int sc, input int n);
    vec_t v;
    v.sel = sel; v.rst = rst; v.req = rq; v.rdy = rd;
    v.ro = ro; v.busy = bz; v.flt = fl; v.lc = lc; v.sc = sc; v.n = n;
    tbl.push_back(v);
  endtask

  // Release timing with ready already high: stage k falls at edge
  // d + k*(d+1) after the restart edge, busy one edge after the last stage.
  function automatic logic [2:0] seq_ro(input int m, input int s, input int d);
    logic [2:0] r;
    r = 3'b000;
    for (int k = 0; k < s; k++) r[k] = (m < d + k * (d + 1));
    return r;
  endfunction

  function automatic bit seq_busy(input int m, input int s, input int d);
    return (m < d + (s - 1) * (d + 1) + 1);
  endfunction

  task automatic check(input vec_t e);
    logic [2:0] g_ro;
    logic       g_bz, g_fl;
    logic [1:0] g_lc;
    logic [2:0] w_ro;
    if (e.sel) begin
      g_ro = {2'b00, reset_out_b}; g_bz = busy_b; g_fl = fault_b; g_lc = last_cause_b;
      w_ro = {2'b00, e.ro[0]};
    end else begin
      g_ro = reset_out_a; g_bz = busy_a; g_fl = fault_a; g_lc = last_cause_a;
      w_ro = e.ro;
    end
    applied++;
    if (g_ro !== w_ro || g_bz !== e.busy || g_fl !== e.flt || g_lc !== e.lc) begin
      miscompares++;
      $display("FAIL sc%0d n%0d: got ro=%b busy=%b fault=%b cause=%b, want ro=%b busy=%b fault=%b cause=%b",
               e.sc, e.n, g_ro, g_bz, g_fl, g_lc, w_ro, e.busy, e.flt, e.lc);
    end
  endtask

  task automatic apply_table();
    vec_t v, e;
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      if (!v.sel) begin
        reset_a = v.rst; req_a = v.req; ready_a = v.rdy;
      end else begin
        reset_b = v.rst; req_b = v.req; ready_b = v.rdy[0];
      end
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check(e);
    end
    tbl.delete();
  endtask

  // Reset pulse, then edges 1..24 with ready[1] low: stall in ACK(1).
  task automatic stall_prefix(input int sc);
    add(0, 1, 2'b00, 3'b101, 3'b111, 1, 0, 2'b00, sc, 0);
    for (int n = 1; n <= 24; n++)
      add(0, 0, 2'b00, 3'b101, (n <= 9) ? seq_ro(n, 3, 4) : 3'b100, 1, 0, 2'b00, sc, n);
  endtask

  initial begin
    vec_t e;
    @(posedge clk);
    #1;

    // sc1: plain release after reset_in, ready all high
    add(0, 1, 2'b00, 3'b111, 3'b111, 1, 0, 2'b00, 1, 0);
    for (int n = 1; n <= 16; n++)
      add(0, 0, 2'b00, 3'b111, seq_ro(n, 3, 4), seq_busy(n, 3, 4), 0, 2'b00, 1, n);

    // sc4: one-cycle req=10 from RUN, timing repeats
    add(0, 0, 2'b10, 3'b111, 3'b111, 1, 0, 2'b10, 4, 0);
    for (int n = 1; n <= 16; n++)
      add(0, 0, 2'b00, 3'b111, seq_ro(n, 3, 4), seq_busy(n, 3, 4), 0, 2'b10, 4, n);

    // sc5: req=01 held 10 cycles while in DELAY(1)
    add(0, 1, 2'b00, 3'b111, 3'b111, 1, 0, 2'b00, 5, 0);
    for (int n = 1; n <= 6; n++)
      add(0, 0, 2'b00, 3'b111, seq_ro(n, 3, 4), 1, 0, 2'b00, 5, n);
    for (int n = 7; n <= 16; n++)
      add(0, 0, 2'b01, 3'b111, 3'b111, 1, 0, 2'b01, 5, n);
    for (int m = 1; m <= 16; m++)
      add(0, 0, 2'b00, 3'b111, seq_ro(m, 3, 4), seq_busy(m, 3, 4), 0, 2'b01, 5, 16 + m);

    // sc2: ready[1] timeout, then ready[1] raised during the retry
    stall_prefix(2);
    add(0, 0, 2'b00, 3'b101, 3'b111, 1, 1, 2'b00, 2, 25);
    for (int m = 1; m <= 16; m++)
      add(0, 0, 2'b00, (m < 2) ? 3'b101 : 3'b111, seq_ro(m, 3, 4), seq_busy(m, 3, 4), 1, 2'b00, 2, 25 + m);

    // sc3: ready[1] arrives on the 16th ACK edge
    stall_prefix(3);
    add(0, 0, 2'b00, 3'b111, 3'b100, 1, 0, 2'b00, 3, 25);
    for (int n = 26; n <= 28; n++)
      add(0, 0, 2'b00, 3'b111, 3'b100, 1, 0, 2'b00, 3, n);
    add(0, 0, 2'b00, 3'b111, 3'b000, 1, 0, 2'b00, 3, 29);
    add(0, 0, 2'b00, 3'b111, 3'b000, 0, 0, 2'b00, 3, 30);

    // sc7: request on the timeout edge wins, fault not set
    stall_prefix(7);
    add(0, 0, 2'b11, 3'b101, 3'b111, 1, 0, 2'b11, 7, 25);
    add(0, 0, 2'b00, 3'b101, 3'b111, 1, 0, 2'b11, 7, 26);

    // sc6: fault, then park in ACK(2) with ready[2] low
    stall_prefix(6);
    add(0, 0, 2'b00, 3'b101, 3'b111, 1, 1, 2'b00, 6, 25);
    for (int m = 1; m <= 17; m++)
      add(0, 0, 2'b00, 3'b011, (m <= 14) ? seq_ro(m, 3, 4) : 3'b000, 1, 1, 2'b00, 6, 25 + m);

    apply_table();

    // Asynchronous reset_in mid-cycle, no clock edge before the check
    #3;
    reset_a = 1'b1;
    e.sel = 0; e.rst = 1; e.req = 2'b00; e.rdy = 3'b011;
    e.ro = 3'b111; e.busy = 1; e.flt = 0; e.lc = 2'b00; e.sc = 9; e.n = 0;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    check(e);
    @(posedge clk);
    #1;

    // sc8: STAGES=1, STAGE_DELAY=1, TIMEOUT=1 boundary instance
    add(1, 1, 2'b00, 3'b001, 3'b001, 1, 0, 2'b00, 8, 0);
    add(1, 0, 2'b00, 3'b001, seq_ro(1, 1, 1), seq_busy(1, 1, 1), 0, 2'b00, 8, 1);
    add(1, 0, 2'b00, 3'b001, seq_ro(2, 1, 1), seq_busy(2, 1, 1), 0, 2'b00, 8, 2);
    add(1, 1, 2'b00, 3'b000, 3'b001, 1, 0, 2'b00, 8, 10);
    add(1, 0, 2'b00, 3'b000, 3'b000, 1, 0, 2'b00, 8, 11);
    add(1, 0, 2'b00, 3'b000, 3'b001, 1, 1, 2'b00, 8, 12);
    add(1, 0, 2'b00, 3'b000, 3'b000, 1, 1, 2'b00, 8, 13);
    add(1, 0, 2'b00, 3'b001, 3'b000, 0, 1, 2'b00, 8, 14);
    add(1, 0, 2'b01, 3'b001, 3'b001, 1, 1, 2'b01, 8, 15);
    add(1, 0, 2'b00, 3'b001, 3'b000, 1, 1, 2'b01, 8, 16);
    add(1, 0, 2'b00, 3'b001, 3'b000, 0, 1, 2'b01, 8, 17);
    apply_table();

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, applied=%0d", applied);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
